// File: rtl/adc_avg_pkg.sv
// rtl/adc_avg_pkg.sv - shared widths and sample/channel types for the ADC channel averager
package adc_avg_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef logic [ADC_DATA_W-1:0] adc_sample_t;
    typedef logic [ADC_CH_W-1:0]   adc_ch_t;

endpackage

// File: rtl/adc_avg_hyst_cmp.sv
// rtl/adc_avg_hyst_cmp.sv - absolute-difference dead-band compare, built only with ADC_AVG_HYST_EN
module adc_avg_hyst_cmp
    import adc_avg_pkg::*;
#(
    parameter int HYST = 8
) (
    input  logic [ADC_DATA_W-1:0] a,
    input  logic [ADC_DATA_W-1:0] b,
    output logic                  far
);

    logic [ADC_DATA_W-1:0] diff;

    // |a - b| compared against the dead band; far means the change is large enough to report
    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
        far  = ({{(32-ADC_DATA_W){1'b0}}, diff} >= 32'(HYST));
    end

endmodule

// File: rtl/adc_channel_avg.sv
// rtl/adc_channel_avg.sv - per-channel windowed ADC averager with latest-value bank (ADC_AVG_HYST_EN adds hysteresis)
module adc_channel_avg
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH   = 9,
    parameter int LOG2_AVG = 4,
    parameter int HYST     = 8
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  in_valid,
    input  logic [ADC_CH_W-1:0]   in_channel,
    input  logic [ADC_DATA_W-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  out_valid,
    output logic [ADC_CH_W-1:0]   out_channel,
    output logic [ADC_DATA_W-1:0] out_data,
    input  logic [ADC_CH_W-1:0]   rd_channel,
    output logic [ADC_DATA_W-1:0] rd_data
);

    localparam int ACC_W = ADC_DATA_W + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [ACC_W:0]   RND      = (ACC_W+1)'((1 << LOG2_AVG) >> 1);

    logic [ACC_W-1:0]      acc  [NUM_CH];
    logic [CNT_W-1:0]      cnt  [NUM_CH];
    logic [ADC_DATA_W-1:0] last [NUM_CH];

    logic                  ch_hit;
    logic [ACC_W-1:0]      acc_sel;
    logic [CNT_W-1:0]      cnt_sel;
    logic                  accept;
    logic                  close;
    logic                  report;
    logic [ACC_W:0]        sum_rnd;
    logic [ADC_DATA_W-1:0] avg;
    logic [ADC_DATA_W-1:0] rd_next;

    // sop/eop carry no information: every beat is a whole packet
    logic unused_inputs;
    assign unused_inputs = in_sop ^ in_eop;

    // select the addressed channel's window state; out-of-range channels never hit
    always_comb begin
        ch_hit  = 1'b0;
        acc_sel = '0;
        cnt_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_channel == ADC_CH_W'(i)) begin
                ch_hit  = 1'b1;
                acc_sel = acc[i];
                cnt_sel = cnt[i];
            end
        end
    end

    assign accept  = in_valid & ch_hit;
    assign close   = accept && (cnt_sel == CNT_LAST);
    assign sum_rnd = {1'b0, acc_sel} + (ACC_W+1)'(in_data) + RND;
    assign avg     = ADC_DATA_W'(sum_rnd >> LOG2_AVG);

`ifdef ADC_AVG_HYST_EN
    logic                  seen [NUM_CH];
    logic [ADC_DATA_W-1:0] last_sel;
    logic                  seen_sel;
    logic                  far;

    // previous report of the addressed channel, for the dead-band decision
    always_comb begin
        last_sel = '0;
        seen_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_channel == ADC_CH_W'(i)) begin
                last_sel = last[i];
                seen_sel = seen[i];
            end
        end
    end

    adc_avg_hyst_cmp #(
        .HYST (HYST)
    ) u_hyst_cmp (
        .a   (avg),
        .b   (last_sel),
        .far (far)
    );

    assign report = close && (!seen_sel || far);
`else
    logic unused_hyst;
    assign unused_hyst = HYST[0];
    assign report      = close;
`endif

    // latest-value bank read mux; unknown channels read as zero
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_channel == ADC_CH_W'(i)) begin
                rd_next = last[i];
            end
        end
    end

    // window accumulation, result strobe and registered read port
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            rd_data     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]  <= '0;
                cnt[i]  <= '0;
                last[i] <= '0;
`ifdef ADC_AVG_HYST_EN
                seen[i] <= 1'b0;
`endif
            end
        end else begin
            out_valid <= report;
            if (report) begin
                out_channel <= in_channel;
                out_data    <= avg;
            end
            rd_data <= rd_next;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && (in_channel == ADC_CH_W'(i))) begin
                    if (close) begin
                        acc[i] <= '0;
                        cnt[i] <= '0;
                        if (report) begin
                            last[i] <= avg;
`ifdef ADC_AVG_HYST_EN
                            seen[i] <= 1'b1;
`endif
                        end
                    end else begin
                        acc[i] <= acc[i] + ACC_W'(in_data);
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_channel_avg.sv
// tb/tb_adc_channel_avg.sv - directed table and sequence checks for adc_channel_avg
module tb_adc_channel_avg;
    import adc_avg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic        in_valid;
    logic [4:0]  in_channel;
    logic [11:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic        out_valid;
    logic [4:0]  out_channel;
    logic [11:0] out_data;
    logic [4:0]  rd_channel;
    logic [11:0] rd_data;

    always #5 clk = ~clk;

    adc_channel_avg #(
        .NUM_CH   (9),
        .LOG2_AVG (4),
        .HYST     (8)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .in_valid    (in_valid),
        .in_channel  (in_channel),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .out_valid   (out_valid),
        .out_channel (out_channel),
        .out_data    (out_data),
        .rd_channel  (rd_channel),
        .rd_data     (rd_data)
    );

    typedef struct {
        int ch;
        int data;
        int n;
        int exp_strobes;
        int exp_data;
        int exp_rd;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_n = 0;
    int base;
    logic [4:0]  log_ch   [$];
    logic [11:0] log_data [$];

    always @(negedge clk) begin
        if (out_valid) begin
            strobe_n++;
            log_ch.push_back(out_channel);
            log_data.push_back(out_data);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int ch, input int d);
        @(negedge clk);
        in_valid   = 1'b1;
        in_channel = ch[4:0];
        in_data    = d[11:0];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic burst(input int ch, input int d, input int n);
        for (int k = 0; k < n; k++) send(ch, d);
    endtask

    task automatic read_chk(input string name, input int ch, input int exp);
        @(negedge clk);
        in_valid   = 1'b0;
        rd_channel = ch[4:0];
        @(negedge clk);
        check(name, int'(rd_data), exp);
    endtask

    task automatic last_strobe_chk(input string name, input int ch, input int d);
        if (log_ch.size() == 0) begin
            check({name, "_present"}, 0, 1);
        end else begin
            check({name, "_ch"}, int'(log_ch[$]), ch);
            check({name, "_data"}, int'(log_data[$]), d);
        end
    endtask

    initial begin
        vecs[0] = '{ch: 3, data: 100,  n: 16, exp_strobes: 1, exp_data: 100,  exp_rd: 100};
        vecs[1] = '{ch: 1, data: 4095, n: 16, exp_strobes: 1, exp_data: 4095, exp_rd: 4095};
        vecs[2] = '{ch: 7, data: 10,   n: 15, exp_strobes: 0, exp_data: 0,    exp_rd: 0};
        vecs[3] = '{ch: 7, data: 18,   n: 1,  exp_strobes: 1, exp_data: 11,   exp_rd: 11};
        vecs[4] = '{ch: 8, data: 0,    n: 16, exp_strobes: 1, exp_data: 0,    exp_rd: 0};
        vecs[5] = '{ch: 9, data: 100,  n: 16, exp_strobes: 0, exp_data: 0,    exp_rd: 0};
        vecs[6] = '{ch: 31, data: 77,  n: 16, exp_strobes: 0, exp_data: 0,    exp_rd: 0};

        reset_reset = 1'b1;
        in_valid    = 1'b0;
        in_channel  = '0;
        in_data     = '0;
        in_sop      = 1'b1;
        in_eop      = 1'b1;
        rd_channel  = '0;
        idle(3);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_channel", int'(out_channel), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        reset_reset = 1'b0;
        idle(1);

        for (int v = 0; v < 7; v++) begin
            base = strobe_n;
            burst(vecs[v].ch, vecs[v].data, vecs[v].n);
            idle(2);
            check($sformatf("vec%0d_strobes", v), strobe_n - base, vecs[v].exp_strobes);
            if (vecs[v].exp_strobes > 0)
                last_strobe_chk($sformatf("vec%0d", v), vecs[v].ch, vecs[v].exp_data);
            read_chk($sformatf("vec%0d_rd", v), vecs[v].ch, vecs[v].exp_rd);
        end

        // rounding of a ramp: 0..15 sums to 120 -> 8
        base = strobe_n;
        for (int k = 0; k < 16; k++) send(0, k);
        idle(2);
        check("ramp_strobes", strobe_n - base, 1);
        last_strobe_chk("ramp", 0, 8);

        // exact one-cycle latency and single-cycle strobe
        burst(3, 100, 15);
        send(3, 100);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_valid_hi", int'(out_valid), 1);
        check("lat_channel", int'(out_channel), 3);
        @(negedge clk);
        check("lat_valid_lo", int'(out_valid), 0);

        // read of a channel updated on the same edge: old value, then new
        rd_channel = 5'd3;
        burst(3, 200, 16);
        @(negedge clk);
        in_valid = 1'b0;
        check("rdsame_old", int'(rd_data), 100);
        @(negedge clk);
        check("rdsame_new", int'(rd_data), 200);

        // ch2/ch5 interleave with out-of-range ch20 beats mixed in
        base = strobe_n;
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0) send(2, 40);
            else send(5, k);
            if (k % 4 == 3) send(20, 4095);
        end
        idle(2);
        check("ilv_strobes", strobe_n - base, 2);
        if (log_ch.size() >= 2) begin
            check("ilv_first_ch", int'(log_ch[log_ch.size()-2]), 2);
            check("ilv_first_data", int'(log_data[log_data.size()-2]), 40);
        end else begin
            check("ilv_first_present", log_ch.size(), 2);
        end
        last_strobe_chk("ilv_second", 5, 16);
        read_chk("ilv_rd_ch20", 20, 0);
        read_chk("ilv_rd_ch2", 2, 40);

        // hysteresis stimulus on ch6: windows of 100, 105, 108
        base = strobe_n;
        burst(6, 100, 16);
        idle(2);
        check("hyst_w1_strobes", strobe_n - base, 1);
        read_chk("hyst_w1_rd", 6, 100);
        base = strobe_n;
        burst(6, 105, 16);
        idle(2);
`ifdef ADC_AVG_HYST_EN
        check("hyst_w2_strobes", strobe_n - base, 0);
        read_chk("hyst_w2_rd", 6, 100);
`else
        check("hyst_w2_strobes", strobe_n - base, 1);
        last_strobe_chk("hyst_w2", 6, 105);
        read_chk("hyst_w2_rd", 6, 105);
`endif
        base = strobe_n;
        burst(6, 108, 16);
        idle(2);
        check("hyst_w3_strobes", strobe_n - base, 1);
        last_strobe_chk("hyst_w3", 6, 108);
        read_chk("hyst_w3_rd", 6, 108);

        // reset mid-window discards the partial sum; samples during reset ignored
        burst(4, 7, 10);
        @(negedge clk);
        reset_reset = 1'b1;
        in_valid    = 1'b1;
        in_channel  = 5'd4;
        in_data     = 12'd7;
        @(negedge clk);
        reset_reset = 1'b0;
        in_valid    = 1'b0;
        read_chk("rstmid_rd0", 4, 0);
        read_chk("rstmid_rd_ch3", 3, 0);
        base = strobe_n;
        burst(4, 50, 15);
        idle(2);
        check("rstmid_15_strobes", strobe_n - base, 0);
        read_chk("rstmid_rd15", 4, 0);
        send(4, 50);
        idle(2);
        check("rstmid_16_strobes", strobe_n - base, 1);
        last_strobe_chk("rstmid_16", 4, 50);
        read_chk("rstmid_rd16", 4, 50);

        // a closing sample coinciding with reset produces no strobe
        burst(8, 3, 15);
        @(negedge clk);
        reset_reset = 1'b1;
        in_valid    = 1'b1;
        in_channel  = 5'd8;
        in_data     = 12'd3;
        base        = strobe_n;
        @(negedge clk);
        reset_reset = 1'b0;
        in_valid    = 1'b0;
        idle(2);
        check("rstclose_strobes", strobe_n - base, 0);
        read_chk("rstclose_rd", 8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
